// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame write sequencer: FSM states, sync word,
// command opcodes and command-word field positions.
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNCED  = 3'd1,
        LOAD    = 3'd2,
        DISCARD = 3'd3,
        STROBE  = 3'd4
    } seq_state_e;

    localparam logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1;
    localparam logic [3:0]  OP_FRAME_WRITE = 4'h1;
    localparam logic [3:0]  OP_DESYNC      = 4'h2;

    localparam int OP_LSB  = 28;
    localparam int OP_W    = 4;
    localparam int COL_LSB = 8;
    localparam int FRM_LSB = 0;
    localparam int ADDR_W  = 8;

    function automatic logic [OP_W-1:0] cmd_opcode(input logic [31:0] w);
        return w[OP_LSB +: OP_W];
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_column(input logic [31:0] w);
        return w[COL_LSB +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_frame(input logic [31:0] w);
        return w[FRM_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational (column, frame, enable) -> one-hot frame strobe vector.
// Addresses outside the fabric decode to all zeros.
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int NumberOfCols    = 8,
    parameter int MaxFramesPerCol = 20
) (
    input  logic [ADDR_W-1:0]                          col,
    input  logic [ADDR_W-1:0]                          frame,
    input  logic                                       enable,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]    strobe
);

    // one-hot decode of the column/frame address
    always_comb begin
        strobe = '0;
        for (int c = 0; c < NumberOfCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                strobe[c*MaxFramesPerCol + f] = enable
                                                && (col == ADDR_W'(c))
                                                && (frame == ADDR_W'(f));
            end
        end
    end

endmodule

// File: rtl/frame_write_sequencer.sv
// Sequences a frame-based bitstream load: sync, command decode, row-by-row
// frame assembly and a timed one-hot frame strobe into the fabric.
module frame_write_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int NumberOfRows    = 16,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfCols    = 8,
    parameter int StrobeCycles    = 2
) (
    input  logic                                     CLK,
    input  logic                                     reset,
    input  logic [FrameBitsPerRow-1:0]               WriteData,
    input  logic                                     WriteValid,
    output logic                                     WriteReady,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                     Synced,
    output logic                                     Busy,
    output logic                                     Error,
    output logic [15:0]                              FrameCount
);

    localparam int FrameW  = NumberOfRows * FrameBitsPerRow;
    localparam int StrobeW = NumberOfCols * MaxFramesPerCol;
    localparam int RowW    = $clog2(NumberOfRows);
    localparam int TmrW    = $clog2(StrobeCycles + 1);
    localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);
    localparam logic [TmrW-1:0] LastTmr = TmrW'(StrobeCycles - 1);

    seq_state_e          state_q,  state_d;
    logic [RowW-1:0]     row_q,    row_d;
    logic [ADDR_W-1:0]   col_q,    col_d;
    logic [ADDR_W-1:0]   frm_q,    frm_d;
    logic [FrameW-1:0]   data_q,   data_d;
    logic [StrobeW-1:0]  strobe_q, strobe_d;
    logic                synced_q, synced_d;
    logic                error_q,  error_d;
    logic [15:0]         count_q,  count_d;
    logic [TmrW-1:0]     tmr_q,    tmr_d;

    logic                accept_s;
    logic [OP_W-1:0]     cmd_op_s;
    logic [ADDR_W-1:0]   cmd_col_s;
    logic [ADDR_W-1:0]   cmd_frm_s;
    logic                addr_ok_s;
    logic                dec_en_s;
    logic [StrobeW-1:0]  dec_strobe_s;

    // Ready depends on the state register only, never on WriteValid.
    assign WriteReady = (state_q != STROBE);
    assign accept_s   = WriteValid && WriteReady;

    assign cmd_op_s  = cmd_opcode(WriteData);
    assign cmd_col_s = cmd_column(WriteData);
    assign cmd_frm_s = cmd_frame(WriteData);
    assign addr_ok_s = (cmd_col_s < ADDR_W'(NumberOfCols))
                       && (cmd_frm_s < ADDR_W'(MaxFramesPerCol));

    assign dec_en_s = (state_q == LOAD) && accept_s && (row_q == LastRow);

    frame_strobe_decoder #(
        .NumberOfCols    (NumberOfCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe_decoder (
        .col    (col_q),
        .frame  (frm_q),
        .enable (dec_en_s),
        .strobe (dec_strobe_s)
    );

    // next-state and datapath update for the sequencer
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        frm_d    = frm_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        synced_d = synced_q;
        error_d  = error_q;
        count_d  = count_q;
        tmr_d    = tmr_q;
        case (state_q)
            IDLE: begin
                if (accept_s && (WriteData == SYNC_WORD)) begin
                    state_d  = SYNCED;
                    synced_d = 1'b1;
                    error_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNCED: begin
                if (accept_s && (WriteData != SYNC_WORD)) begin
                    case (cmd_op_s)
                        OP_DESYNC: begin
                            state_d  = IDLE;
                            synced_d = 1'b0;
                        end
                        OP_FRAME_WRITE: begin
                            row_d = '0;
                            if (addr_ok_s) begin
                                col_d   = cmd_col_s;
                                frm_d   = cmd_frm_s;
                                state_d = LOAD;
                            end else begin
                                error_d = 1'b1;
                                state_d = DISCARD;
                            end
                        end
                        default: begin
                            error_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = SYNCED;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    for (int r = 0; r < NumberOfRows; r++) begin
                        if (row_q == RowW'(r)) begin
                            data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = WriteData;
                        end else begin
                            data_d[r*FrameBitsPerRow +: FrameBitsPerRow] =
                                data_q[r*FrameBitsPerRow +: FrameBitsPerRow];
                        end
                    end
                    if (row_q == LastRow) begin
                        state_d  = STROBE;
                        strobe_d = dec_strobe_s;
                        tmr_d    = '0;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            DISCARD: begin
                if (accept_s) begin
                    if (row_q == LastRow) begin
                        state_d = SYNCED;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end else begin
                    state_d = DISCARD;
                end
            end
            STROBE: begin
                // The strobe timer runs regardless of WriteValid.
                if (tmr_q == LastTmr) begin
                    strobe_d = '0;
                    count_d  = count_q + 16'd1;
                    state_d  = SYNCED;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                strobe_d = '0;
            end
        endcase
    end

    // sequencer state and output registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            frm_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            synced_q <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= 16'd0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frm_q    <= frm_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            synced_q <= synced_d;
            error_q  <= error_d;
            count_q  <= count_d;
            tmr_q    <= tmr_d;
        end
    end

    assign Busy        = (state_q == LOAD) || (state_q == DISCARD) || (state_q == STROBE);
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign Synced      = synced_q;
    assign Error       = error_q;
    assign FrameCount  = count_q;

endmodule
